// File: rtl/dmc_port_arbiter.sv
// Two-port round-robin arbiter and sequencer for the CPU side of the direct-mapped cache controller.
// Optional watchdog in WAIT is enabled by defining DMC_ARB_TIMEOUT_EN.
module dmc_port_arbiter #(
    parameter int BLOCK_SIZE     = 4,
    parameter int ADDRESS_SIZE   = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    p0_req_valid_i,
    input  logic                    p0_req_write_i,
    input  logic [ADDRESS_SIZE-1:0] p0_req_address_i,
    input  logic [BLOCK_SIZE-1:0]   p0_req_data_i,
    output logic                    p0_req_ready_o,
    output logic                    p0_resp_valid_o,
    input  logic                    p1_req_valid_i,
    input  logic                    p1_req_write_i,
    input  logic [ADDRESS_SIZE-1:0] p1_req_address_i,
    input  logic [BLOCK_SIZE-1:0]   p1_req_data_i,
    output logic                    p1_req_ready_o,
    output logic                    p1_resp_valid_o,
    output logic [BLOCK_SIZE-1:0]   resp_data_o,
    output logic                    resp_err_o,
    output logic                    cache_start_o,
    output logic                    cache_read_o,
    output logic                    cache_write_o,
    output logic [ADDRESS_SIZE-1:0] cache_address_o,
    output logic [BLOCK_SIZE-1:0]   cache_data_o,
    input  logic                    cache_ready_i,
    input  logic [BLOCK_SIZE-1:0]   cache_data_i,
    output logic                    busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_BLANK = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    rr_last_r;
    logic                    gnt_port_r;
    logic                    wr_r;
    logic [ADDRESS_SIZE-1:0] addr_r;
    logic [BLOCK_SIZE-1:0]   data_r;
    logic [BLOCK_SIZE-1:0]   resp_data_r;
    logic                    grant_s;
    logic                    grant_port_s;
    logic                    done_ok_s;
    logic                    timeout_hit_s;

    // Round-robin grant decision, only meaningful while idle
    always_comb begin
        grant_s      = 1'b0;
        grant_port_s = 1'b0;
        if (state_r == ST_IDLE) begin
            case ({p1_req_valid_i, p0_req_valid_i})
                2'b01: begin
                    grant_s      = 1'b1;
                    grant_port_s = 1'b0;
                end
                2'b10: begin
                    grant_s      = 1'b1;
                    grant_port_s = 1'b1;
                end
                2'b11: begin
                    grant_s      = 1'b1;
                    grant_port_s = ~rr_last_r;
                end
                default: begin
                    grant_s      = 1'b0;
                    grant_port_s = 1'b0;
                end
            endcase
        end else begin
            grant_s      = 1'b0;
            grant_port_s = 1'b0;
        end
    end

    // Ready in BLANK is ignored because it may be left over from the previous transaction
    assign done_ok_s = (state_r == ST_WAIT) && cache_ready_i;

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_BLANK;
            ST_BLANK: state_s = ST_WAIT;
            ST_WAIT: begin
                if (done_ok_s || timeout_hit_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latch and round-robin history; rr_last starts at 1 so port 0 wins first
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_last_r  <= 1'b1;
            gnt_port_r <= 1'b0;
            wr_r       <= 1'b0;
            addr_r     <= {ADDRESS_SIZE{1'b0}};
            data_r     <= {BLOCK_SIZE{1'b0}};
        end else if (grant_s) begin
            rr_last_r  <= grant_port_s;
            gnt_port_r <= grant_port_s;
            wr_r       <= grant_port_s ? p1_req_write_i   : p0_req_write_i;
            addr_r     <= grant_port_s ? p1_req_address_i : p0_req_address_i;
            data_r     <= grant_port_s ? p1_req_data_i    : p0_req_data_i;
        end
    end

    // Response data capture, held until the next completion
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            resp_data_r <= {BLOCK_SIZE{1'b0}};
        end else if (done_ok_s) begin
            resp_data_r <= wr_r ? {BLOCK_SIZE{1'b0}} : cache_data_i;
        end else if (timeout_hit_s) begin
            resp_data_r <= {BLOCK_SIZE{1'b0}};
        end
    end

`ifdef DMC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] to_cnt_r;
    logic             resp_err_r;

    // A ready arriving in the final watchdog cycle still completes normally
    assign timeout_hit_s = (state_r == ST_WAIT) && !cache_ready_i &&
                           (to_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter, cleared in BLANK so it starts at zero on WAIT entry
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            to_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_BLANK) begin
            to_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_WAIT) && !cache_ready_i) begin
            to_cnt_r <= to_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Error flag captured alongside the response data
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            resp_err_r <= 1'b0;
        end else if (done_ok_s) begin
            resp_err_r <= 1'b0;
        end else if (timeout_hit_s) begin
            resp_err_r <= 1'b1;
        end
    end

    assign resp_err_o = resp_err_r;
`else
    assign timeout_hit_s = 1'b0;
    assign resp_err_o    = 1'b0;
`endif

    assign p0_req_ready_o  = grant_s & ~grant_port_s;
    assign p1_req_ready_o  = grant_s &  grant_port_s;
    assign p0_resp_valid_o = (state_r == ST_RESP) & ~gnt_port_r;
    assign p1_resp_valid_o = (state_r == ST_RESP) &  gnt_port_r;
    assign resp_data_o     = resp_data_r;
    assign cache_start_o   = (state_r == ST_ISSUE);
    assign cache_read_o    = (state_r == ST_ISSUE) & ~wr_r;
    assign cache_write_o   = (state_r == ST_ISSUE) &  wr_r;
    assign cache_address_o = addr_r;
    assign cache_data_o    = data_r;
    assign busy_o          = (state_r != ST_IDLE);

endmodule
